// File: rtl/chan_capture_sequencer.sv
// chan_capture_sequencer
// Sequences a single channelizer capture from the software control register.
// A 0->1 edge on the start bit arms the sequencer. It then optionally waits for
// the channelizer frame sync, gates exactly `length` valid samples through
// capture_en, and reports progress and errors in a status word for readback.
// ctrl_word is already in the user_clk domain. It is registered twice so that
// the start edge can be detected, which means the FSM reacts on the second
// clock edge after software writes the register.

module chan_capture_sequencer #(
  parameter int LEN_W     = 24,          // length field / sample counter width (status_word[31:8])
  parameter int TIMEOUT_W = 20,          // ARM timeout counter width
  parameter int SYNC_TMO  = 2**20 - 1    // ARM cycles without sync_in before timeout (>= 1)
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] ctrl_word,
  input  logic        sync_in,
  input  logic        sample_valid,
  output logic        capture_en,
  output logic        start_pulse,
  output logic        busy,
  output logic [31:0] status_word
);

  // State encoding doubles as the status_word[1:0] field seen by software.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Last ARM timer value before giving up on the frame sync.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(SYNC_TMO - 1);

  // Control register pipeline.
  logic [31:0]          ctrl_q_reg;
  logic                 start_qq_reg;

  // Decoded control fields, all taken from the first pipeline stage.
  logic                 start_rise;
  logic                 abort_req;
  logic                 ext_sync_en;
  logic [LEN_W-1:0]     ctrl_len;
  logic                 ctrl_unused;

  // Sequencer state and its next-state values.
  state_t               state_reg,       state_next;
  logic [LEN_W-1:0]     len_reg,         len_next;
  logic [LEN_W-1:0]     count_reg,       count_next;
  logic [TIMEOUT_W-1:0] timer_reg,       timer_next;
  logic                 done_reg,        done_next;
  logic                 tmo_err_reg,     tmo_err_next;
  logic                 len_err_reg,     len_err_next;

  // Registered strobes derived from the next state.
  logic                 capture_en_reg,  capture_en_next;
  logic                 start_pulse_reg, start_pulse_next;
  logic                 busy_reg,        busy_next;

  // Last sample of the capture: the counter is one short of the latched length.
  logic                 last_sample;

  assign start_rise  = ctrl_q_reg[0] & ~start_qq_reg;
  assign abort_req   = ctrl_q_reg[1];
  assign ext_sync_en = ctrl_q_reg[2];
  assign ctrl_len    = ctrl_q_reg[8 +: LEN_W];
  // Bits [7:3] of the control register are reserved and deliberately ignored.
  assign ctrl_unused = ^ctrl_q_reg[7:3];

  assign last_sample = (count_reg == (len_reg - LEN_W'(1)));

  // Two-stage control register pipeline used for start edge detection.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q_reg   <= '0;
      start_qq_reg <= 1'b0;
    end else begin
      ctrl_q_reg   <= ctrl_word;
      start_qq_reg <= ctrl_q_reg[0];
    end
  end

  // Sequencer state, counters, sticky flags and registered output strobes.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_reg       <= ST_IDLE;
      len_reg         <= '0;
      count_reg       <= '0;
      timer_reg       <= '0;
      done_reg        <= 1'b0;
      tmo_err_reg     <= 1'b0;
      len_err_reg     <= 1'b0;
      capture_en_reg  <= 1'b0;
      start_pulse_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      len_reg         <= len_next;
      count_reg       <= count_next;
      timer_reg       <= timer_next;
      done_reg        <= done_next;
      tmo_err_reg     <= tmo_err_next;
      len_err_reg     <= len_err_next;
      capture_en_reg  <= capture_en_next;
      start_pulse_reg <= start_pulse_next;
      busy_reg        <= busy_next;
    end
  end

  // Next-state logic: start/abort handling, sync wait with timeout, and sample gating.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    count_next   = count_reg;
    timer_next   = timer_reg;
    done_next    = done_reg;
    tmo_err_next = tmo_err_reg;
    len_err_next = len_err_reg;

    case (state_reg)
      ST_IDLE: begin
        // Only a fresh start edge is accepted, and only from IDLE.
        if (start_rise) begin
          if (ctrl_len == '0) begin
            // Zero-length request: flag it and do nothing else.
            len_err_next = 1'b1;
          end else begin
            len_next     = ctrl_len;
            count_next   = '0;
            timer_next   = '0;
            done_next    = 1'b0;
            tmo_err_next = 1'b0;
            len_err_next = 1'b0;
            state_next   = ext_sync_en ? ST_ARM : ST_RUN;
          end
        end
      end

      ST_ARM: begin
        // Abort has the highest priority. A sync arriving on the final
        // timeout cycle still starts the capture.
        if (abort_req) begin
          done_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (sync_in) begin
          state_next = ST_RUN;
        end else if (timer_reg == TMO_LAST) begin
          tmo_err_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          timer_next = timer_reg + TIMEOUT_W'(1);
        end
      end

      ST_RUN: begin
        // Abort wins over the last sample. The count is kept so software can
        // see how far the capture got.
        if (abort_req) begin
          done_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (capture_en_reg && sample_valid) begin
          if (last_sample) begin
            count_next = len_reg;
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            count_next = count_reg + LEN_W'(1);
          end
        end
      end

      ST_DONE: begin
        // Hold here until software drops the start bit, so a start bit left
        // high can never re-arm the sequencer. The done flag persists into IDLE.
        if (!ctrl_q_reg[0]) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Output strobes are registered copies of the upcoming state, so they
    // line up with status_word on the same edge.
    capture_en_next  = (state_next == ST_RUN);
    start_pulse_next = (state_next == ST_RUN) && (state_reg != ST_RUN);
    busy_next        = (state_next == ST_ARM) || (state_next == ST_RUN);
  end

  assign capture_en  = capture_en_reg;
  assign start_pulse = start_pulse_reg;
  assign busy        = busy_reg;
  assign status_word = {count_reg, 3'b000, len_err_reg, tmo_err_reg, done_reg, state_reg};

endmodule

// File: tb/tb_chan_capture_sequencer.sv
// Testbench for chan_capture_sequencer.
// Two instances share one stimulus stream: one with a long sync timeout and one
// with a short one. A behavioural model predicts every output of both instances
// each cycle. Directed scenarios pin the model and the DUTs to hand-computed
// values, and a randomized phase follows.

module tb_chan_capture_sequencer;

  localparam int TMO0 = 200;
  localparam int TMO1 = 64;

  logic        user_clk     = 1'b0;
  logic        user_rst_n   = 1'b0;
  logic [31:0] ctrl_word    = '0;
  logic        sync_in      = 1'b0;
  logic        sample_valid = 1'b0;

  logic        cap_o  [2];
  logic        sp_o   [2];
  logic        busy_o [2];
  logic [31:0] stat_o [2];

  always #5 user_clk = ~user_clk;

  chan_capture_sequencer #(.LEN_W(24), .TIMEOUT_W(20), .SYNC_TMO(TMO0)) u_dut0 (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .ctrl_word    (ctrl_word),
    .sync_in      (sync_in),
    .sample_valid (sample_valid),
    .capture_en   (cap_o[0]),
    .start_pulse  (sp_o[0]),
    .busy         (busy_o[0]),
    .status_word  (stat_o[0])
  );

  chan_capture_sequencer #(.LEN_W(24), .TIMEOUT_W(20), .SYNC_TMO(TMO1)) u_dut1 (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .ctrl_word    (ctrl_word),
    .sync_in      (sync_in),
    .sample_valid (sample_valid),
    .capture_en   (cap_o[1]),
    .start_pulse  (sp_o[1]),
    .busy         (busy_o[1]),
    .status_word  (stat_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbers are the status codes software reads: 0 idle, 1 waiting for
  // sync, 2 capturing, 3 finished.
  int          m_ph   [2];
  int          m_len  [2];
  int          m_cnt  [2];
  int          m_arm  [2];   // ARM cycles elapsed in this attempt
  bit          m_done [2];
  bit          m_tmo  [2];
  bit          m_lerr [2];
  bit          m_cap  [2];
  bit          m_sp   [2];
  bit          m_busy [2];
  logic [31:0] m_seen1;      // ctrl_word as seen one edge ago
  logic [31:0] m_seen2;      // ctrl_word as seen two edges ago

  function automatic int tmo_of(input int i);
    return (i == 0) ? TMO0 : TMO1;
  endfunction

  function automatic logic [31:0] model_status(input int i);
    logic [31:0] c;
    c = m_cnt[i];
    return {c[23:0], 3'b000, m_lerr[i], m_tmo[i], m_done[i], 2'(m_ph[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_arm[i] = 0;
      m_done[i] = 0; m_tmo[i] = 0; m_lerr[i] = 0;
      m_cap[i] = 0; m_sp[i] = 0; m_busy[i] = 0;
    end
    m_seen1 = '0;
    m_seen2 = '0;
  endtask

  task automatic model_step(input int i);
    bit start_edge;
    int prev;
    start_edge = m_seen1[0] && !m_seen2[0];
    prev = m_ph[i];
    case (m_ph[i])
      0: if (start_edge) begin
           if (m_seen1[31:8] == 0) m_lerr[i] = 1;
           else begin
             m_len[i] = int'(m_seen1[31:8]);
             m_cnt[i] = 0; m_arm[i] = 0;
             m_done[i] = 0; m_tmo[i] = 0; m_lerr[i] = 0;
             m_ph[i] = m_seen1[2] ? 1 : 2;
           end
         end
      1: if (m_seen1[1]) begin m_ph[i] = 0; m_done[i] = 0; end
         else if (sync_in) m_ph[i] = 2;
         else begin
           m_arm[i]++;
           if (m_arm[i] == tmo_of(i)) begin m_tmo[i] = 1; m_ph[i] = 0; end
         end
      2: if (m_seen1[1]) begin m_ph[i] = 0; m_done[i] = 0; end
         else if (sample_valid) begin
           m_cnt[i]++;
           if (m_cnt[i] == m_len[i]) begin m_ph[i] = 3; m_done[i] = 1; end
         end
      default: if (!m_seen1[0]) m_ph[i] = 0;
    endcase
    m_cap[i]  = (m_ph[i] == 2);
    m_sp[i]   = (m_ph[i] == 2) && (prev != 2);
    m_busy[i] = (m_ph[i] == 1) || (m_ph[i] == 2);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge user_clk or negedge user_rst_n);
      if (!user_rst_n) model_reset();
      else begin
        for (int i = 0; i < 2; i++) model_step(i);
        m_seen2 = m_seen1;
        m_seen1 = ctrl_word;
      end
    end
  end

  // ---------------- per-cycle compare + activity counters ----------------
  int capc [2];
  int spc  [2];
  int busyc[2];
  int gated0 = 0;

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin capc[i] = 0; spc[i] = 0; busyc[i] = 0; end
    gated0 = 0;
  endtask

  initial begin
    clr_stats();
    forever begin
      @(negedge user_clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("capture_en[%0d]", i), 32'(cap_o[i]), 32'(m_cap[i]));
        check($sformatf("start_pulse[%0d]", i), 32'(sp_o[i]), 32'(m_sp[i]));
        check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_busy[i]));
        check($sformatf("status_word[%0d]", i), stat_o[i], model_status(i));
        if (cap_o[i] === 1'b1) capc[i]++;
        if (sp_o[i] === 1'b1) spc[i]++;
        if (busy_o[i] === 1'b1) busyc[i]++;
      end
      if (cap_o[0] === 1'b1 && sample_valid) gated0++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc     = 0;
  int sv_mode = 0;   // 0: every cycle, 1: every 3rd cycle, 2: random ~75%
  int sync_at = -1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge user_clk);
      #2;
      cyc++;
      case (sv_mode)
        0:       sample_valid = 1'b1;
        1:       sample_valid = (cyc % 3 == 0);
        default: sample_valid = ($urandom_range(0, 3) != 0);
      endcase
      sync_in = (cyc == sync_at);
    end
  endtask

  task automatic start(input int len, input bit ext);
    logic [23:0] l;
    l = 24'(len);
    ctrl_word = '0;
    tick(3);
    clr_stats();
    ctrl_word = {l, 5'b00000, ext, 1'b0, 1'b1};
  endtask

  task automatic wait_state(input int i, input logic [1:0] st, input int limit, input string name);
    int k;
    k = 0;
    while (stat_o[i][1:0] !== st && k < limit) begin tick(); k++; end
    check({name, "_state_reached"}, 32'(stat_o[i][1:0]), 32'(st));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int len;
    bit ext;
    int abort_at;
    int glitch_at;

    // ---- reset state ----
    tick(3);
    check("reset_status0", stat_o[0], 32'h0);
    check("reset_busy0", 32'(busy_o[0]), 32'h0);
    check("reset_model_status", model_status(0), 32'h0);
    user_rst_n = 1'b1;
    tick(2);

    // ---- 1: len=16, no ext sync, valid every cycle ----
    sv_mode = 0;
    start(16, 1'b0);
    tick();
    check("t1_cap_latency_edge1", 32'(cap_o[0]), 32'h0);
    tick();
    check("t1_cap_latency_edge2", 32'(cap_o[0]), 32'h1);
    check("t1_start_pulse_on", 32'(sp_o[0]), 32'h1);
    tick();
    check("t1_start_pulse_off", 32'(sp_o[0]), 32'h0);
    wait_state(0, 2'd3, 100, "t1");
    check("t1_cap_cycles", capc[0], 32'd16);
    check("t1_pulse_count", spc[0], 32'd1);
    check("t1_status", stat_o[0], 32'h0000_1007);
    check("t1_model_status", model_status(0), 32'h0000_1007);
    ctrl_word = '0;
    tick(4);
    check("t1_idle_done_held", stat_o[0], 32'h0000_1004);
    $display("test1: len=16 capture, cap_cycles=%0d", capc[0]);

    // ---- 2: len=5, valid every 3rd cycle ----
    sv_mode = 1;
    start(5, 1'b0);
    wait_state(0, 2'd3, 100, "t2");
    check("t2_gated_samples", gated0, 32'd5);
    check("t2_status", stat_o[0], 32'h0000_0507);
    $display("test2: len=5 sparse valid, gated=%0d cap_cycles=%0d", gated0, capc[0]);

    // ---- 3: ext sync, len=8, sync after ~100 ARM cycles ----
    sv_mode = 0;
    start(8, 1'b1);
    sync_at = cyc + 102;
    while (cyc < sync_at) tick();
    check("t3_cap_before_sync", 32'(cap_o[0]), 32'h0);
    check("t3_state_arm", 32'(stat_o[0][1:0]), 32'd1);
    tick();
    check("t3_cap_after_sync", 32'(cap_o[0]), 32'h1);
    check("t3_pulse_after_sync", 32'(sp_o[0]), 32'h1);
    wait_state(0, 2'd3, 50, "t3");
    sync_at = -1;
    check("t3_gated_samples", gated0, 32'd8);
    check("t3_busy_cycles", busyc[0], 32'd109);
    check("t3_status", stat_o[0], 32'h0000_0807);
    check("t3_short_tmo_status", stat_o[1], 32'h0000_0008);
    check("t3_short_tmo_busy", busyc[1], 32'd64);
    check("t3_short_tmo_cap", capc[1], 32'd0);
    $display("test3: ext sync, busy0=%0d busy1=%0d", busyc[0], busyc[1]);

    // ---- 4: ext sync, no sync_in -> timeout ----
    start(8, 1'b1);
    tick(3);
    k = 0;
    while (busy_o[0] !== 1'b0 && k < 400) begin tick(); k++; end
    check("t4_bounded_wait", 32'(k < 400), 32'h1);
    check("t4_busy_cycles_64", busyc[1], 32'd64);
    check("t4_busy_cycles_200", busyc[0], 32'd200);
    check("t4_status1", stat_o[1], 32'h0000_0008);
    check("t4_status0", stat_o[0], 32'h0000_0008);
    check("t4_cap_never", capc[0] + capc[1], 32'd0);
    $display("test4: sync timeout, arm cycles %0d / %0d", busyc[0], busyc[1]);

    // ---- 5a: zero length start ----
    start(0, 1'b0);
    tick(3);
    check("t5_len_err_status", stat_o[0], 32'h0000_0018);
    check("t5_len_err_busy", busyc[0], 32'd0);

    // ---- 5b: abort at count 37 ----
    start(1000, 1'b0);
    k = 0;
    while (stat_o[0][31:8] !== 24'd36 && k < 100) begin tick(); k++; end
    check("t5_reach_36", 32'(stat_o[0][31:8]), 32'd36);
    ctrl_word[1] = 1'b1;
    tick(2);
    check("t5_abort_status", stat_o[0], 32'h0000_2500);
    check("t5_abort_cap", 32'(cap_o[0]), 32'h0);
    check("t5_abort_model", model_status(0), 32'h0000_2500);

    // ---- 5c: start held in DONE does not re-arm ----
    start(4, 1'b0);
    wait_state(0, 2'd3, 50, "t5c");
    clr_stats();
    tick(500);
    check("t5_hold_state", 32'(stat_o[0][1:0]), 32'd3);
    check("t5_hold_cap", capc[0], 32'd0);
    check("t5_hold_pulse", spc[0], 32'd0);
    ctrl_word = '0;
    tick(3);
    check("t5_release_status", stat_o[0], 32'h0000_0404);
    $display("test5: len_err, abort at 37, held start in DONE");

    // ---- 6: async reset mid-run ----
    start(50, 1'b0);
    k = 0;
    while (stat_o[0][31:8] < 24'd10 && k < 100) begin tick(); k++; end
    check("t6_running", 32'(stat_o[0][1:0]), 32'd2);
    user_rst_n = 1'b0;
    ctrl_word = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_rst_cap[%0d]", i), 32'(cap_o[i]), 32'h0);
      check($sformatf("t6_rst_busy[%0d]", i), 32'(busy_o[i]), 32'h0);
      check($sformatf("t6_rst_status[%0d]", i), stat_o[i], 32'h0);
    end
    tick();
    user_rst_n = 1'b1;
    start(20, 1'b0);
    wait_state(0, 2'd3, 100, "t6");
    check("t6_after_reset_status", stat_o[0], 32'h0000_1407);
    check("t6_after_reset_cap", capc[0], 32'd20);
    $display("test6: reset mid-run, fresh capture done");

    // ---- randomized transactions ----
    for (int t = 0; t < 40; t++) begin
      len     = $urandom_range(0, 40);
      ext     = 1'($urandom_range(0, 1));
      sv_mode = $urandom_range(0, 2);
      start(len, ext);
      sync_at   = (ext && $urandom_range(0, 3) != 0) ? cyc + $urandom_range(1, 120) : -1;
      abort_at  = ($urandom_range(0, 4) == 0) ? cyc + $urandom_range(1, 40) : -1;
      glitch_at = ($urandom_range(0, 5) == 0) ? cyc + $urandom_range(1, 30) : -1;
      k = 0;
      do begin
        tick();
        k++;
        if (cyc == abort_at) ctrl_word[1] = 1'b1;
        if (cyc == glitch_at) ctrl_word[0] = ~ctrl_word[0];
      end while ((k < 4 || busy_o[0] === 1'b1 || busy_o[1] === 1'b1) && k < 500);
      check("rand_bounded_wait", 32'(k < 500), 32'h1);
      sync_at = -1;
      $display("rand %0d: len=%0d ext=%0d mode=%0d status0=0x%08h status1=0x%08h",
               t, len, ext, sv_mode, stat_o[0], stat_o[1]);
    end

    ctrl_word = '0;
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
